muldiv_seq: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS datapath. It iterates MULT/MULTU/DIV/DIVU over n cycles, reports busy/done to the pipeline, and serves MFHI/MFLO/MTHI/MTLO. It sits beside the single-cycle ALU in the execute stage and replaces the ALU's one-shot negedge multiply with a properly handshaked, clock-edge-only unit.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_signfix.sv | 16 +
 rtl/muldiv_seq.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned MD_N     = 32;
  localparam int unsigned MD_CNT_W = $clog2(MD_N);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  function automatic logic op_is_div(input op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate. With neg = signed & x[msb] it yields
// |x|; with neg = sign mismatch it applies the result sign correction.
module muldiv_signfix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  // Negate when requested, pass through otherwise.
  always_comb begin
    y = neg ? (~x + W'(1)) : x;
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO register pair.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [MD_N-1:0] a,
  input  logic [MD_N-1:0] b,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [MD_N-1:0] wdata,
  input  logic            rd_req,
  output logic [MD_N-1:0] hi,
  output logic [MD_N-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            stall
);

  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*MD_N-1:0]     acc_q, acc_d;
  logic [MD_N-1:0]       opnd_q, opnd_d;
  logic [MD_N-1:0]       a_raw_q, a_raw_d;
  logic                  sign_a_q, sign_a_d;
  logic                  sign_b_q, sign_b_d;
  logic                  b_zero_q, b_zero_d;
  logic [MD_N-1:0]       hi_q, hi_d;
  logic [MD_N-1:0]       lo_q, lo_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  op_t                   op_in;
  logic                  in_signed;
  logic [MD_N-1:0]       a_mag, b_mag;
  logic [2*MD_N-1:0]     prod_fix;
  logic [MD_N-1:0]       quo_fix, rem_fix;

  logic [MD_N:0]         mul_sum;
  logic [2*MD_N-1:0]     mul_next;
  logic [MD_N:0]         div_trial, div_diff;
  logic                  div_ge;
  logic [2*MD_N-1:0]     div_next;

  assign op_in     = op_t'(op);
  assign in_signed = op_is_signed(op_in);

  muldiv_signfix #(.W(MD_N)) u_abs_a (
    .x   (a),
    .neg (in_signed & a[MD_N-1]),
    .y   (a_mag)
  );

  muldiv_signfix #(.W(MD_N)) u_abs_b (
    .x   (b),
    .neg (in_signed & b[MD_N-1]),
    .y   (b_mag)
  );

  muldiv_signfix #(.W(2*MD_N)) u_fix_prod (
    .x   (acc_q),
    .neg (sign_a_q ^ sign_b_q),
    .y   (prod_fix)
  );

  muldiv_signfix #(.W(MD_N)) u_fix_quo (
    .x   (acc_q[MD_N-1:0]),
    .neg (sign_a_q ^ sign_b_q),
    .y   (quo_fix)
  );

  muldiv_signfix #(.W(MD_N)) u_fix_rem (
    .x   (acc_q[2*MD_N-1:MD_N]),
    .neg (sign_a_q),
    .y   (rem_fix)
  );

  // One iteration step: shift-add multiply or restoring shift-subtract divide.
  // Multiply keeps {partial, multiplier} and shifts right; divide keeps
  // {remainder, dividend/quotient} and shifts left, quotient bits enter at bit 0.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*MD_N-1:MD_N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[MD_N-1:1]};
    div_trial = acc_q[2*MD_N-1:MD_N-1];
    div_diff  = div_trial - {1'b0, opnd_q};
    div_ge    = ~div_diff[MD_N];
    div_next  = {(div_ge ? div_diff[MD_N-1:0] : div_trial[MD_N-1:0]),
                 acc_q[MD_N-2:0], div_ge};
  end

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_d     = op_in;
          cnt_d    = '0;
          a_raw_d  = a;
          sign_a_d = in_signed & a[MD_N-1];
          sign_b_d = in_signed & b[MD_N-1];
          b_zero_d = (b == '0);
          if (op_is_div(op_in)) begin
            acc_d  = {{MD_N{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{MD_N{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
          state_d = CALC;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = op_is_div(op_q) ? div_next : mul_next;
        cnt_d = cnt_q + MD_CNT_W'(1);
        if (cnt_q == MD_CNT_W'(MD_N - 1)) state_d = FIX;
      end
      FIX: begin
        if (op_is_div(op_q)) begin
          if (b_zero_q) begin
            lo_d = '1;
            hi_d = a_raw_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          hi_d = prod_fix[2*MD_N-1:MD_N];
          lo_d = prod_fix[MD_N-1:0];
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  // State and architectural registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_MULT;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      a_raw_q  <= a_raw_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign stall = busy_q & (rd_req | mthi | mtlo | start);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        rd_req = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int total = 0;
  int bad = 0;

  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .rd_req(rd_req),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one cycle; returns in cycle 1 after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called in cycle 1; lat ends as the cycle index of done (34 expected).
  task automatic wait_done(output int lat, output int nbusy);
    lat = 1;
    nbusy = busy ? 1 : 0;
    while (done !== 1'b1 && lat < 100) begin
      step();
      lat++;
      if (busy === 1'b1) nbusy++;
    end
  endtask

  task automatic test_reset();
    #1;
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL reset_hilo hi=%h lo=%h want 0", hi, lo); end
    total++; if ({busy, done, stall} !== 3'b000) begin bad++; $display("FAIL reset_flags bds=%b want 000", {busy, done, stall}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mul();
    int lat, nb;
    issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done(lat, nb);
    total++; if (lat !== 34) begin bad++; $display("FAIL mult_latency got=%0d want=34", lat); end
    total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult hi=%h lo=%h want ffffffff fffffffe", hi, lo); end
    step();
    issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done(lat, nb);
    total++; if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu hi=%h lo=%h want 00000001 fffffffe", hi, lo); end
    step();
  endtask

  task automatic test_div();
    int lat, nb;
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(lat, nb);
    total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg hi=%h lo=%h want ffffffff fffffffd", hi, lo); end
    step();
    issue(2'b11, 32'h0000_0007, 32'h0000_0000);
    wait_done(lat, nb);
    total++; if (lat !== 34) begin bad++; $display("FAIL divz_latency got=%0d want=34", lat); end
    total++; if (hi !== 32'h0000_0007 || lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu_zero hi=%h lo=%h want 00000007 ffffffff", hi, lo); end
    step();
    issue(2'b11, 32'd100, 32'd7);
    wait_done(lat, nb);
    total++; if (hi !== 32'd2 || lo !== 32'd14) begin bad++; $display("FAIL divu hi=%h lo=%h want 2 14", hi, lo); end
    step();
  endtask

  task automatic test_minneg();
    int lat, nb;
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, nb);
    total++; if (hi !== 32'h0 || lo !== 32'h8000_0000) begin bad++; $display("FAIL div_minneg hi=%h lo=%h want 0 80000000", hi, lo); end
    total++; if (nb !== 33) begin bad++; $display("FAIL busy_cycles got=%0d want=33", nb); end
    step();
  endtask

  task automatic test_stall_read();
    int lat;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_AAAA;
    step();
    mthi = 1'b0; mtlo = 1'b0;
    issue(2'b01, 32'h0001_0000, 32'h0001_0000);
    for (int i = 0; i < 9; i++) step();
    rd_req = 1'b1; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_busy_rd got=%b want=1", stall); end
    total++; if (hi !== 32'h0000_AAAA || lo !== 32'h0000_AAAA) begin bad++; $display("FAIL hold_in_calc hi=%h lo=%h want aaaa aaaa", hi, lo); end
    rd_req = 1'b0;
    lat = 10;
    while (done !== 1'b1 && lat < 100) begin step(); lat++; end
    total++; if (lat !== 34) begin bad++; $display("FAIL rd_latency got=%0d want=34", lat); end
    rd_req = 1'b1; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_done_rd got=%b want=0", stall); end
    total++; if (hi !== 32'h1 || lo !== 32'h0) begin bad++; $display("FAIL read_in_done hi=%h lo=%h want 1 0", hi, lo); end
    rd_req = 1'b0;
    step();
  endtask

  task automatic test_mt();
    int lat, nb;
    mthi = 1'b1; wdata = 32'h0000_1234;
    step();
    mthi = 1'b0;
    total++; if (hi !== 32'h0000_1234) begin bad++; $display("FAIL mthi_idle got=%h want=00001234", hi); end
    issue(2'b01, 32'd2, 32'd3);
    for (int i = 0; i < 4; i++) step();
    mtlo = 1'b1; wdata = 32'h0000_DEAD; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_mtlo got=%b want=1", stall); end
    step();
    mtlo = 1'b0;
    total++; if (lo !== 32'h0000_0000) begin bad++; $display("FAIL mtlo_busy got=%h want=00000000", lo); end
    wait_done(lat, nb);
    total++; if (hi !== 32'h0 || lo !== 32'd6) begin bad++; $display("FAIL mult_after_mtlo hi=%h lo=%h want 0 6", hi, lo); end
    step();
    mthi = 1'b1; wdata = 32'h0000_9999;
    issue(2'b01, 32'd4, 32'd5);
    mthi = 1'b0;
    total++; if (hi !== 32'h0 || busy !== 1'b1) begin bad++; $display("FAIL mthi_with_start hi=%h busy=%b want 0 1", hi, busy); end
    wait_done(lat, nb);
    total++; if (hi !== 32'h0 || lo !== 32'd20) begin bad++; $display("FAIL mult_4x5 hi=%h lo=%h want 0 20", hi, lo); end
    step();
  endtask

  task automatic test_reset_mid();
    int lat, nb;
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int i = 0; i < 14; i++) step();
    rst_n = 1'b0; #1;
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL midreset_hilo hi=%h lo=%h want 0", hi, lo); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midreset_flags busy=%b done=%b want 0 0", busy, done); end
    step();
    rst_n = 1'b1;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle busy=%b want 0", busy); end
    issue(2'b01, 32'd3, 32'd5);
    wait_done(lat, nb);
    total++; if (lat !== 34 || hi !== 32'h0 || lo !== 32'd15) begin bad++; $display("FAIL post_reset_mul lat=%0d hi=%h lo=%h want 34 0 15", lat, hi, lo); end
    step();
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    issue(2'b01, 32'd6, 32'd7);
    wait_done(lat, nb);
    total++; if (lo !== 32'd42) begin bad++; $display("FAIL b2b_first lo=%h want 42", lo); end
    issue(2'b01, 32'd8, 32'd9);
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL b2b_no_bubble busy=%b done=%b want 1 0", busy, done); end
    wait_done(lat, nb);
    total++; if (lat !== 34) begin bad++; $display("FAIL b2b_latency got=%0d want=34", lat); end
    total++; if (hi !== 32'h0 || lo !== 32'd72) begin bad++; $display("FAIL b2b_second hi=%h lo=%h want 0 72", hi, lo); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b want=0", done); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_minneg();
    test_stall_read();
    test_mt();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
